// File: rtl/apb_timer_sched.sv
// APB-programmable two-channel (lo/hi) prescaled timer with compare IRQs and optional 64-bit cascade.
// Optional debug freeze via stop_i is enabled by defining APB_TIMER_SCHED_STOP_EN.
module apb_timer_sched #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ref_tick_i,
  input  logic              stop_i,
  output logic              irq_lo_o,
  output logic              irq_hi_o,
  output logic              busy_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] A_CFG_LO   = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] A_CFG_HI   = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] A_CNT_LO   = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] A_CNT_HI   = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] A_START_LO = ADDR_W'('h18);
  localparam logic [ADDR_W-1:0] A_START_HI = ADDR_W'('h1C);
  localparam logic [ADDR_W-1:0] A_RST_LO   = ADDR_W'('h20);
  localparam logic [ADDR_W-1:0] A_RST_HI   = ADDR_W'('h24);

  state_t             r_state [2];
  logic [1:0]         r_irq_en, r_one_shot, r_cmp_clr, r_presc_en, r_ref_sel;
  logic [PRESC_W-1:0] r_presc [2];
  logic [PRESC_W-1:0] r_pcnt  [2];
  logic [CNT_W-1:0]   r_cnt   [2];
  logic [CNT_W-1:0]   r_cmp   [2];
  logic               r_casc, r_irq_lo, r_irq_hi, r_busy;

  logic               w_acc, w_wr, w_mapped, w_stop;
  logic [31:0]        w_rdata;
  logic [31:0]        w_cfg_rd [2];
  logic [1:0]         w_wr_cfg, w_wr_cnt, w_wr_cmp, w_wr_start, w_wr_rst;
  logic [1:0]         w_src, w_prun, w_pwrap, w_run_adv, w_adv, w_match, w_clr;
  state_t             w_nxt [2];
  logic [PRESC_W-1:0] w_new_presc;

`ifdef APB_TIMER_SCHED_STOP_EN
  assign w_stop = stop_i;
`else
  logic w_unused_stop;
  assign w_unused_stop = stop_i;
  assign w_stop        = 1'b0;
`endif

  assign w_acc       = psel & penable;
  assign w_wr        = w_acc & pwrite;
  assign w_new_presc = pwdata[8 +: PRESC_W];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      w_cfg_rd[i] = {((i == 0) ? r_casc : 1'b0), 15'b0, 8'(r_presc[i]), 1'b0, r_ref_sel[i],
                     r_presc_en[i], r_cmp_clr[i], r_one_shot[i], r_irq_en[i], 1'b0,
                     (r_state[i] == ST_RUN)};
    end
  end

  always_comb begin
    w_mapped   = 1'b1;
    w_rdata    = '0;
    w_wr_cfg   = '0;
    w_wr_cnt   = '0;
    w_wr_cmp   = '0;
    w_wr_start = '0;
    w_wr_rst   = '0;
    case (paddr)
      A_CFG_LO:   begin w_rdata = w_cfg_rd[0];     w_wr_cfg[0]   = w_wr; end
      A_CFG_HI:   begin w_rdata = w_cfg_rd[1];     w_wr_cfg[1]   = w_wr; end
      A_CNT_LO:   begin w_rdata = 32'(r_cnt[0]);   w_wr_cnt[0]   = w_wr; end
      A_CNT_HI:   begin w_rdata = 32'(r_cnt[1]);   w_wr_cnt[1]   = w_wr; end
      A_CMP_LO:   begin w_rdata = 32'(r_cmp[0]);   w_wr_cmp[0]   = w_wr; end
      A_CMP_HI:   begin w_rdata = 32'(r_cmp[1]);   w_wr_cmp[1]   = w_wr; end
      A_START_LO: w_wr_start[0] = w_wr;
      A_START_HI: w_wr_start[1] = w_wr;
      A_RST_LO:   w_wr_rst[0]   = w_wr;
      A_RST_HI:   w_wr_rst[1]   = w_wr;
      default:    w_mapped      = 1'b0;
    endcase
  end

  assign prdata   = (w_acc & w_mapped) ? w_rdata : '0;
  assign pslverr  = w_acc & ~w_mapped;
  assign pready   = 1'b1;
  assign irq_lo_o = r_irq_lo;
  assign irq_hi_o = r_irq_hi;
  assign busy_o   = r_busy;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      w_src[i]     = r_ref_sel[i] ? ref_tick_i : 1'b1;
      w_prun[i]    = (r_state[i] == ST_RUN) & w_src[i] & ~w_stop;
      w_pwrap[i]   = ~r_presc_en[i] | (r_pcnt[i] == r_presc[i]);
      w_run_adv[i] = w_prun[i] & w_pwrap[i];
    end
    // In cascade the hi counter is a carry extension of lo and its own FSM is bypassed.
    w_adv[0]   = w_run_adv[0];
    w_adv[1]   = r_casc ? (w_run_adv[0] & (&r_cnt[0])) : w_run_adv[1];
    w_match[0] = w_adv[0] & (r_casc ? ({r_cnt[1], r_cnt[0]} == {r_cmp[1], r_cmp[0]})
                                    : (r_cnt[0] == r_cmp[0]));
    w_match[1] = ~r_casc & w_adv[1] & (r_cnt[1] == r_cmp[1]);
    w_clr[0]   = w_match[0] & r_cmp_clr[0];
    w_clr[1]   = r_casc ? w_clr[0] : (w_match[1] & r_cmp_clr[1]);
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      w_nxt[i] = r_state[i];
      if (w_match[i] & r_one_shot[i]) w_nxt[i] = ST_IDLE;
      if (w_wr_cfg[i])                w_nxt[i] = pwdata[0] ? ST_RUN : ST_IDLE;
      if (w_wr_start[i])              w_nxt[i] = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_state[i] <= ST_IDLE;
        r_presc[i] <= '0;
        r_pcnt[i]  <= '0;
        r_cnt[i]   <= '0;
        r_cmp[i]   <= '0;
      end
      r_irq_en   <= '0;
      r_one_shot <= '0;
      r_cmp_clr  <= '0;
      r_presc_en <= '0;
      r_ref_sel  <= '0;
      r_casc     <= 1'b0;
      r_irq_lo   <= 1'b0;
      r_irq_hi   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_state[i] <= w_nxt[i];
        if (w_wr_cfg[i]) begin
          r_irq_en[i]   <= pwdata[2];
          r_one_shot[i] <= pwdata[3];
          r_cmp_clr[i]  <= pwdata[4];
          r_presc_en[i] <= pwdata[5];
          r_ref_sel[i]  <= pwdata[6];
          r_presc[i]    <= w_new_presc;
        end
        if (w_wr_cmp[i]) r_cmp[i] <= pwdata[CNT_W-1:0];
        if (w_wr_rst[i])       r_cnt[i] <= '0;
        else if (w_wr_cnt[i])  r_cnt[i] <= pwdata[CNT_W-1:0];
        else if (w_clr[i])     r_cnt[i] <= '0;
        else if (w_adv[i])     r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        if (w_wr_rst[i] | (w_wr_cfg[i] & (w_new_presc != r_presc[i])))
          r_pcnt[i] <= '0;
        else if (w_prun[i] & r_presc_en[i])
          r_pcnt[i] <= w_pwrap[i] ? '0 : r_pcnt[i] + PRESC_W'(1);
      end
      if (w_wr_cfg[0]) r_casc <= pwdata[31];
      r_irq_lo <= w_match[0] & r_irq_en[0];
      r_irq_hi <= w_match[1] & r_irq_en[1];
      r_busy   <= (w_nxt[0] == ST_RUN) | (w_nxt[1] == ST_RUN);
    end
  end

endmodule
